// File: rtl/shifter_pkg.sv
// Shared encodings and width helpers for the pipelined barrel shifter.
package shifter_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // Shift-amount width, which is also the number of pipeline stages.
  function automatic int unsigned shamt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered stage of the shifter: applies a fixed distance DIST when its
// shift-amount bit is set, then holds the result until the successor takes it.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DIST  = 1,
  localparam int unsigned SHAMT_W = shamt_w(WIDTH),
  localparam int unsigned BIT     = $clog2(DIST)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               up_valid,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_amt,
  input  op_e                up_op,
  input  logic [TAG_W-1:0]   up_tag,
  input  logic               dn_advance,
  output logic               advance_c,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [SHAMT_W-1:0] amt,
  output op_e                op,
  output logic [TAG_W-1:0]   tag
);

  logic [WIDTH-1:0] shifted;

  // Stage may load whenever it is empty or its current content moves on.
  assign advance_c = !valid || dn_advance;

  // Fixed-distance shift; SRA keeps replicating the MSB, which earlier SRA
  // stages have preserved, so the fill always equals the operand's sign.
  always_comb begin
    shifted = up_data;
    if (up_amt[BIT]) begin
      case (up_op)
        OP_SLL:  shifted = up_data << DIST;
        OP_SRL:  shifted = up_data >> DIST;
        OP_SRA:  shifted = WIDTH'($signed(up_data) >>> DIST);
        OP_ROL:  shifted = (up_data << DIST) | (up_data >> (WIDTH - DIST));
        default: shifted = up_data;
      endcase
    end
  end

  // Stage register; flush empties it, otherwise load on advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      amt   <= '0;
      op    <= OP_SLL;
      tag   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (advance_c) begin
      valid <= up_valid;
      data  <= shifted;
      amt   <= up_amt;
      op    <= up_op;
      tag   <= up_tag;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready handshakes,
// one stage per shift-amount bit, largest distance first.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5,
  localparam int unsigned SHAMT_W = shamt_w(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic [OP_W-1:0]    op,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [TAG_W-1:0]   out_tag
);

  logic [SHAMT_W-1:0] up_valid;
  logic [SHAMT_W-1:0] st_valid;
  logic [SHAMT_W-1:0] adv;
  logic [SHAMT_W-1:0] dn_adv;

  logic [WIDTH-1:0]   up_data [SHAMT_W];
  logic [SHAMT_W-1:0] up_amt  [SHAMT_W];
  op_e                up_op   [SHAMT_W];
  logic [TAG_W-1:0]   up_tag  [SHAMT_W];

  logic [WIDTH-1:0]   st_data [SHAMT_W];
  logic [SHAMT_W-1:0] st_amt  [SHAMT_W];
  op_e                st_op   [SHAMT_W];
  logic [TAG_W-1:0]   st_tag  [SHAMT_W];

  // Accept when stage 1 can load and no flush; held low throughout reset.
  assign in_ready = reset_n && adv[0] && !flush;

  // Chain of stages: stage i feeds stage i+1, the last one feeds the output.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign up_valid[i] = in_valid && in_ready;
      assign up_data[i]  = operand;
      assign up_amt[i]   = shift_amt;
      assign up_op[i]    = op_e'(op);
      assign up_tag[i]   = in_tag;
    end else begin : g_chain
      assign up_valid[i] = st_valid[i-1];
      assign up_data[i]  = st_data[i-1];
      assign up_amt[i]   = st_amt[i-1];
      assign up_op[i]    = st_op[i-1];
      assign up_tag[i]   = st_tag[i-1];
    end

    if (i == SHAMT_W - 1) begin : g_last
      assign dn_adv[i] = out_ready;
    end else begin : g_next
      assign dn_adv[i] = adv[i+1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .DIST  (32'(1) << (SHAMT_W - 1 - i))
    ) u_stage (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush      (flush),
      .up_valid   (up_valid[i]),
      .up_data    (up_data[i]),
      .up_amt     (up_amt[i]),
      .up_op      (up_op[i]),
      .up_tag     (up_tag[i]),
      .dn_advance (dn_adv[i]),
      .advance_c  (adv[i]),
      .valid      (st_valid[i]),
      .data       (st_data[i]),
      .amt        (st_amt[i]),
      .op         (st_op[i]),
      .tag        (st_tag[i])
    );
  end

  assign out_valid = st_valid[SHAMT_W-1];
  assign result    = st_data[SHAMT_W-1];
  assign out_tag   = st_tag[SHAMT_W-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=32, TAG_W=5).
module tb_pipelined_shifter;

  localparam int unsigned LAT = 5;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand;
  logic [4:0]  shift_amt;
  logic [1:0]  op;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_tag;

  pipelined_shifter #(.WIDTH(32), .TAG_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand   (operand),
    .shift_amt (shift_amt),
    .op        (op),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [4:0]  a;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int unsigned cyc;
  } exp_t;

  vec_t        vecs [16];
  exp_t        q [$];
  int unsigned n_pass, n_total, cyc, xfer_cnt;
  logic        lat_chk, last_acc, prev_hold;
  logic [31:0] prev_r, exp_res;
  logic [4:0]  prev_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference shift from the mode definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int a, input logic [1:0] o);
    logic signed [31:0] s;
    s = x;
    case (o)
      2'd0:    return x << a;
      2'd1:    return x >> a;
      2'd2:    return s >>> a;
      default: return (a == 0) ? x : ((x << a) | (x >> (32 - a)));
    endcase
  endfunction

  task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [4:0] a,
                       input logic [4:0] t, input logic [31:0] e);
    op = o; operand = x; shift_amt = a; in_tag = t; exp_res = e;
  endtask

  task automatic drive_rand();
    logic [1:0]  o;
    logic [31:0] x;
    logic [4:0]  a;
    o = 2'($urandom_range(0, 3));
    x = $urandom;
    a = 5'($urandom_range(0, 31));
    drive(o, x, a, 5'($urandom_range(0, 31)), ref_shift(x, int'(a), o));
  endtask

  // One clock: sample at negedge, update the scoreboard at the edge.
  task automatic tick();
    logic        acc, xfer, fl;
    logic [31:0] r;
    logic [4:0]  t, ptag;
    exp_t        e;
    @(negedge clock);
    if (prev_hold) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, prev_r);
      chk("hold_out_tag", out_tag, prev_t);
    end
    fl   = flush;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready && !flush;
    r    = result;
    t    = out_tag;
    ptag = in_tag;
    prev_hold = out_valid && !out_ready && !flush;
    prev_r = r;
    prev_t = t;
    @(posedge clock);
    cyc++;
    if (fl) begin
      q.delete();
    end else begin
      if (xfer) begin
        xfer_cnt++;
        chk("result_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("result", r, e.res);
          chk("out_tag", t, e.tag);
          if (lat_chk) chk("latency", cyc - e.cyc, LAT);
        end
      end
      if (acc) q.push_back('{res: exp_res, tag: ptag, cyc: cyc});
    end
    last_acc = acc;
    #1;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1; in_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 40 && q.size() != 0; k++) tick();
    chk({name, "_drained"}, q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  so [7];
    logic [31:0] sx [7];
    logic [4:0]  sa [7];
    logic [4:0]  st [7];
    int          j;
    int unsigned xb;

    vecs[0]  = '{2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{2'd1, 32'hF000_0000, 5'd28, 32'h0000_000F};
    vecs[2]  = '{2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[3]  = '{2'd3, 32'h8000_0001, 5'd1,  32'h0000_0003};
    vecs[4]  = '{2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[5]  = '{2'd1, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[6]  = '{2'd2, 32'h8765_4321, 5'd0,  32'h8765_4321};
    vecs[7]  = '{2'd3, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D};
    vecs[8]  = '{2'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[9]  = '{2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[10] = '{2'd3, 32'h1234_5678, 5'd16, 32'h5678_1234};
    vecs[11] = '{2'd3, 32'h8000_0000, 5'd31, 32'h4000_0000};
    vecs[12] = '{2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[13] = '{2'd0, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000};
    vecs[14] = '{2'd2, 32'hF000_0000, 5'd8,  32'hFFF0_0000};
    vecs[15] = '{2'd3, 32'hF000_0000, 5'd4,  32'h0000_000F};

    n_pass = 0; n_total = 0; cyc = 0; xfer_cnt = 0;
    lat_chk = 1'b1; last_acc = 1'b0; prev_hold = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(2'd0, 32'h0, 5'd0, 5'd0, 32'h0);

    // Reset state
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_result", result, 0);
    chk("reset_out_tag", out_tag, 0);
    #10 reset_n = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    @(posedge clock); cyc++; #1;

    // Directed table, streamed back to back
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].op, vecs[i].x, vecs[i].a, 5'(i), vecs[i].exp);
      in_valid = 1'b1;
      tick();
      chk("table_accept", last_acc, 1);
    end
    drain("table");

    // 20 random back-to-back operations
    xb = xfer_cnt;
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      in_valid = 1'b1;
      tick();
      chk("stream_accept", last_acc, 1);
    end
    drain("stream");
    chk("stream_count", xfer_cnt - xb, 20);

    // Backpressure: 7 offered, 5 fit, then all emerge in order
    for (int i = 0; i < 7; i++) begin
      so[i] = 2'($urandom_range(0, 3)); sx[i] = $urandom;
      sa[i] = 5'($urandom_range(0, 31)); st[i] = 5'(i + 10);
    end
    lat_chk = 1'b0; out_ready = 1'b0; j = 0;
    xb = xfer_cnt;
    for (int c = 0; c < 10; c++) begin
      in_valid = (j < 7);
      if (j < 7) drive(so[j], sx[j], sa[j], st[j], ref_shift(sx[j], int'(sa[j]), so[j]));
      tick();
      if (last_acc) j++;
    end
    chk("stall_accepted", j, 5);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && j < 7; c++) begin
      drive(so[j], sx[j], sa[j], st[j], ref_shift(sx[j], int'(sa[j]), so[j]));
      in_valid = 1'b1;
      tick();
      if (last_acc) j++;
    end
    drain("stall");
    chk("stall_emerged", xfer_cnt - xb, 7);
    lat_chk = 1'b1;

    // Flush with 3 in flight plus a simultaneous input
    for (int i = 0; i < 3; i++) begin
      drive_rand(); in_valid = 1'b1; tick();
    end
    drive_rand(); in_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("flush_out_valid", out_valid, 0);
      tick();
    end
    drive_rand(); in_valid = 1'b1; tick();
    chk("post_flush_accept", last_acc, 1);
    drain("post_flush");

    // Flush while a result is offered with out_ready high
    for (int c = 0; c < 10 && !out_valid; c++) begin
      drive_rand(); in_valid = 1'b1; tick();
    end
    chk("preflush_out_valid", out_valid, 1);
    flush = 1'b1; drive_rand();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("flush_out_out_valid", out_valid, 0);
      tick();
    end

    // Half-cycle reset pulse mid-stream
    for (int c = 0; c < 10 && !out_valid; c++) begin
      drive_rand(); in_valid = 1'b1; tick();
    end
    chk("prereset_out_valid", out_valid, 1);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 0);
    chk("midreset_result", result, 0);
    chk("midreset_out_tag", out_tag, 0);
    #4 reset_n = 1'b1;
    q.delete(); prev_hold = 1'b0;
    #1 chk("postreset_in_ready", in_ready, 1);
    @(posedge clock); cyc++; #1;
    for (int i = 0; i < 8; i++) begin
      chk("postreset_out_valid", out_valid, 0);
      tick();
    end

    // Random traffic with backpressure and occasional flush
    lat_chk = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) drive_rand();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width; legal values are powers of two from 8 to 64.
REQ-002 Parameter TAG_W, default 5, SHALL set the width of the sideband tag carried alongside each operation.
REQ-003 Derived constant SHAMT_W = log2(WIDTH) SHALL set the shift-amount width and the pipeline depth (5 for WIDTH=32).
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL mark that an operation is presented.
REQ-007 in_ready  output  1  SHALL mark that stage 1 accepts an operation this cycle.
REQ-008 operand  input  WIDTH  SHALL be the value to shift.
REQ-009 shift_amt  input  SHAMT_W  SHALL be the unsigned shift distance.
REQ-010 op  input  2  SHALL select the mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-011 in_tag  input  TAG_W  SHALL be sideband data returned unchanged with the result.
REQ-012 flush  input  1  SHALL discard every in-flight operation.
REQ-013 out_valid  output  1  SHALL mark a valid result.
REQ-014 out_ready  input  1  SHALL mark that the consumer takes the result this cycle.
REQ-015 result  output  WIDTH  SHALL be the shifted value.
REQ-016 out_tag  output  TAG_W  SHALL be the tag of the operation on result.

Function
- REQ-017 The block SHALL contain SHAMT_W registered stages; stage k (k=1..SHAMT_W) shifts by 2^(SHAMT_W-k) when its shift_amt bit SHAMT_W-k is set.
  - Largest distance comes first: 16, 8, 4, 2, 1 for WIDTH=32.
- REQ-018 Each stage SHALL register its data, the remaining shift_amt bits, op, tag and a valid bit.
- REQ-019 SLL SHALL fill vacated bits with 0.
- REQ-020 SRL SHALL fill vacated bits with 0.
- REQ-021 SRA SHALL fill vacated bits with operand[WIDTH-1].
- REQ-022 ROL SHALL re-insert the bits shifted out of the MSB end at the LSB end.
- REQ-023 shift_amt=0 SHALL return operand unchanged in every mode.
- REQ-024 Handshake: a transfer SHALL occur on a rising edge where valid and ready are both high; data SHALL be held stable while valid is high and ready is low.
- REQ-025 Stage k SHALL advance when it is empty or its successor advances; the last stage's successor is the out_valid/out_ready transfer.
- REQ-026 in_ready SHALL equal (stage 1 empty or stage 1 advancing) and not flush, so bubbles collapse.
- REQ-027 With out_ready held high, a result SHALL appear exactly SHAMT_W cycles after acceptance.
- REQ-028 Throughput SHALL be one operation per cycle.
- REQ-029 When every stage is full and out_ready is low, the pipeline SHALL hold and in_ready SHALL be 0; no operation SHALL be lost or duplicated.
- REQ-030 Operations SHALL leave in acceptance order.
- REQ-031 flush SHALL clear all valid bits on the next edge.
  - flush wins over a simultaneous in_valid; that input is not accepted.
  - flush wins over a simultaneous out_ready; that result is not transferred.
- REQ-032 out_valid, result and out_tag SHALL be driven directly from last-stage registers.

Reset
REQ-033 Asserting reset_n low SHALL immediately clear all stage valid bits, including mid-operation; in-flight operations are discarded.
REQ-034 While reset_n is low, out_valid, result, out_tag and in_ready SHALL be 0.
REQ-035 After release, in_ready SHALL be 1 on the first clock edge.

Structure
REQ-036 Package shifter_pkg SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROL) and the SHAMT_W derivation function.
REQ-037 One registered stage SHALL be the sub-module shift_stage, parametrised by WIDTH, TAG_W and DIST, instantiated SHAMT_W times in a generate loop.

Verification
REQ-038 SLL 0x00000001 by 31, then SRL 0xF0000000 by 28 -> 0x80000000, then 0x0000000F, each 5 cycles after its acceptance.
REQ-039 SRA 0x80000000 by 4 -> 0xF8000000; ROL 0x80000001 by 1 -> 0x00000003; shift_amt 0 -> operand unchanged.
REQ-040 Back-to-back stream of 20 random operations with out_ready=1 -> one result per cycle, in order, tags matching a reference model.
REQ-041 out_ready=0 with 7 operations offered -> 5 accepted, then in_ready=0; on out_ready=1 all 7 emerge in order with none lost.
REQ-042 flush with 3 operations in flight plus a simultaneous in_valid -> out_valid stays 0 and that input is not accepted; the next accepted operation appears after 5 cycles.
REQ-043 reset_n pulsed low for half a cycle mid-stream -> out_valid drops to 0 immediately, and no stale result appears after release.
